// File: rtl/timer_disp_pkg.sv
// Shared definitions for the timer display driver: field positions of the
// packed time bus, update FSM encoding, active-low 7-segment patterns and the
// decimal-point position mask.
package timer_disp_pkg;

    // digit[26:0] = {hr[4:0], min[5:0], sec[5:0], ms[9:0]}
    localparam int HR_MSB  = 26;
    localparam int HR_LSB  = 22;
    localparam int MIN_MSB = 21;
    localparam int MIN_LSB = 16;
    localparam int SEC_MSB = 15;
    localparam int SEC_LSB = 10;
    localparam int MS_MSB  = 9;
    localparam int MS_LSB  = 0;

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_COMMIT  = 2'd3
    } upd_state_t;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decimal point follows the hr, min and sec units digits: HH.MM.SS.cc
    localparam logic [7:0] DP_MASK = 8'b01010100;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/timer_display_driver_bin2bcd.sv
// Sequential 10-bit binary to 4-digit BCD converter (shift-add-3).
// Ports:
//   clk_1khz, reset_in : clock, async active-high reset
//   start              : one-cycle pulse, loads bin (ignored while busy)
//   bin[9:0]           : value to convert
//   done               : one-cycle pulse exactly 10 cycles after start
//   bcd[15:0]          : {thousands, hundreds, tens, units}, valid on done and
//                        held until the next start
module bin2bcd_seq
    import timer_disp_pkg::*;
(
    input  logic        clk_1khz,
    input  logic        reset_in,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        done,
    output logic [15:0] bcd
);

    // {bcd[15:0], bin[9:0]} working register
    logic [25:0] sr;
    logic [3:0]  remaining;
    logic        busy;

    function automatic logic [25:0] shift_add3(input logic [25:0] x);
        logic [25:0] y;
        y = x;
        for (int i = 0; i < 4; i++) begin
            if (y[10 + 4*i +: 4] >= 4'd5)
                y[10 + 4*i +: 4] = y[10 + 4*i +: 4] + 4'd3;
        end
        return {y[24:0], 1'b0};
    endfunction

    // The load edge also performs the first shift, so the tenth shift lands
    // on the edge that raises done, ten cycles after start.
    always_ff @(posedge clk_1khz or posedge reset_in) begin
        if (reset_in) begin
            sr        <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                sr        <= shift_add3({16'd0, bin});
                remaining <= 4'd9;
                busy      <= 1'b1;
            end else if (busy) begin
                sr        <= shift_add3(sr);
                remaining <= remaining - 4'd1;
                if (remaining == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr[25:10];

endmodule

// File: rtl/timer_display_driver.sv
// Snapshots the countdown timer's packed time bus, converts hr/min/sec/ms to
// BCD with one shared sequential converter and scans an 8-digit common-anode
// display as HH.MM.SS.cc. The whole display blinks while done_in is high.
// Ports:
//   clk_1khz, reset_in : 1 kHz clock, async active-high reset
//   digit[26:0]        : {hr[4:0], min[5:0], sec[5:0], ms[9:0]}
//   done_in            : countdown finished, enables blinking
//   an[7:0]            : active-low digit enables, an[7] = hr tens
//   seg[6:0]           : active-low segments {g,f,e,d,c,b,a}
//   dp                 : active-low decimal point
//   frame_upd          : one-cycle pulse when the display takes a new snapshot
//
// state     | meaning
// S_CAPTURE | latch digit into snap, restart at the hr field
// S_START   | pulse converter start with the current field
// S_WAIT    | wait for converter done, store field BCD in shadow
// S_COMMIT  | copy shadow to display registers, pulse frame_upd
module timer_display_driver
    import timer_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 1,
    parameter int BLINK_HALF = 250
) (
    input  logic        clk_1khz,
    input  logic        reset_in,
    input  logic [26:0] digit,
    input  logic        done_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_upd
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    upd_state_t  state, state_nx;
    logic [1:0]  field_idx;
    logic [26:0] snap;
    logic        conv_start, conv_done;
    logic [9:0]  conv_bin;
    logic [15:0] conv_bcd;
    logic        conv_unused;

    logic [7:0]  sh_hr, sh_min, sh_sec, sh_ms;
    logic [7:0]  disp_hr, disp_min, disp_sec, disp_ms;

    logic [PW-1:0] presc;
    logic [2:0]    scan_idx;
    logic [3:0]    disp_nib;
    logic [BW-1:0] blink_cnt;
    logic          blink_blank;

    bin2bcd_seq u_bin2bcd (
        .clk_1khz (clk_1khz),
        .reset_in (reset_in),
        .start    (conv_start),
        .bin      (conv_bin),
        .done     (conv_done),
        .bcd      (conv_bcd)
    );

    // Thousands digit is never shown (ms thousands is dropped).
    assign conv_unused = ^conv_bcd[15:12];

    always_ff @(posedge clk_1khz or posedge reset_in) begin
        if (reset_in) state <= S_CAPTURE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        conv_start = 1'b0;
        case (field_idx)
            2'd0:    conv_bin = {5'd0, snap[HR_MSB:HR_LSB]};
            2'd1:    conv_bin = {4'd0, snap[MIN_MSB:MIN_LSB]};
            2'd2:    conv_bin = {4'd0, snap[SEC_MSB:SEC_LSB]};
            default: conv_bin = snap[MS_MSB:MS_LSB];
        endcase
        case (state)
            S_CAPTURE: state_nx = S_START;
            S_START: begin
                conv_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT:
                if (conv_done) state_nx = (field_idx == 2'd3) ? S_COMMIT : S_START;
            S_COMMIT:  state_nx = S_CAPTURE;
            default:   state_nx = S_CAPTURE;
        endcase
    end

    assign frame_upd = (state == S_COMMIT);

    always_ff @(posedge clk_1khz or posedge reset_in) begin
        if (reset_in) begin
            snap      <= '0;
            field_idx <= '0;
            sh_hr     <= '0;
            sh_min    <= '0;
            sh_sec    <= '0;
            sh_ms     <= '0;
            disp_hr   <= '0;
            disp_min  <= '0;
            disp_sec  <= '0;
            disp_ms   <= '0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    snap      <= digit;
                    field_idx <= 2'd0;
                end
                S_WAIT:
                    if (conv_done) begin
                        case (field_idx)
                            2'd0:    sh_hr  <= conv_bcd[7:0];
                            2'd1:    sh_min <= conv_bcd[7:0];
                            2'd2:    sh_sec <= conv_bcd[7:0];
                            default: sh_ms  <= conv_bcd[11:4];  // hundreds, tens
                        endcase
                        field_idx <= field_idx + 2'd1;
                    end
                S_COMMIT: begin
                    disp_hr  <= sh_hr;
                    disp_min <= sh_min;
                    disp_sec <= sh_sec;
                    disp_ms  <= sh_ms;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        disp_nib = 4'd0;
        case (scan_idx)
            3'd7: disp_nib = disp_hr[7:4];
            3'd6: disp_nib = disp_hr[3:0];
            3'd5: disp_nib = disp_min[7:4];
            3'd4: disp_nib = disp_min[3:0];
            3'd3: disp_nib = disp_sec[7:4];
            3'd2: disp_nib = disp_sec[3:0];
            3'd1: disp_nib = disp_ms[7:4];
            3'd0: disp_nib = disp_ms[3:0];
            default: disp_nib = 4'd0;
        endcase
    end

    // an, seg and dp all derive from the same scan_idx in one register stage,
    // so the anode and its segment data always change together.
    always_ff @(posedge clk_1khz or posedge reset_in) begin
        if (reset_in) begin
            presc    <= '0;
            scan_idx <= 3'd7;
            an       <= 8'hFF;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc    <= '0;
                scan_idx <= scan_idx - 3'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            an  <= blink_blank ? 8'hFF : ~(8'b1 << scan_idx);
            seg <= seg_encode(disp_nib);
            dp  <= ~DP_MASK[scan_idx];
        end
    end

    always_ff @(posedge clk_1khz or posedge reset_in) begin
        if (reset_in) begin
            blink_cnt   <= '0;
            blink_blank <= 1'b0;
        end else if (!done_in) begin
            blink_cnt   <= '0;
            blink_blank <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_blank <= ~blink_blank;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_timer_display_driver.sv
module tb_timer_display_driver;

    logic        clk_1khz = 1'b0;
    logic        reset_in;
    logic [26:0] digit;
    logic        done_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_upd;

    logic        start;
    logic [9:0]  bin;
    logic        conv_done;
    logic [15:0] bcd;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [26:0] D1 = {5'd12, 6'd34, 6'd56, 10'd789};
    localparam logic [26:0] D2 = {5'd31, 6'd63, 6'd63, 10'd1023};

    always #5 clk_1khz = ~clk_1khz;

    timer_display_driver #(.SCAN_DIV(1), .BLINK_HALF(4)) u_dut (
        .clk_1khz  (clk_1khz),
        .reset_in  (reset_in),
        .digit     (digit),
        .done_in   (done_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_upd (frame_upd)
    );

    bin2bcd_seq u_conv (
        .clk_1khz (clk_1khz),
        .reset_in (reset_in),
        .start    (start),
        .bin      (bin),
        .done     (conv_done),
        .bcd      (bcd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic wait_frame(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk_1khz);
            cycles++;
            @(negedge clk_1khz);
        end while (!frame_upd && cycles < 200);
        check("frame_seen", frame_upd, 1);
    endtask

    // exp holds the expected nibble for scan index i in bits [4i+3:4i].
    task automatic scan_check(input string tag, input logic [31:0] exp);
        logic [7:0] seen;
        int idx;
        seen = '0;
        repeat (2) @(posedge clk_1khz);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_1khz);
            check($sformatf("%s_onehot", tag), $countones(~an), 1);
            idx = 0;
            for (int b = 0; b < 8; b++) if (!an[b]) idx = b;
            seen[idx] = 1'b1;
            check($sformatf("%s_seg%0d", tag, idx), seg, exp_seg(exp[4*idx +: 4]));
            check($sformatf("%s_dp%0d", tag, idx), dp,
                  (idx == 6 || idx == 4 || idx == 2) ? 1'b0 : 1'b1);
        end
        check($sformatf("%s_all_digits", tag), seen, 8'hFF);
    endtask

    task automatic conv_test(input logic [9:0] value, input logic [15:0] exp_bcd);
        int n;
        @(negedge clk_1khz);
        bin   = value;
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk_1khz);
            n++;
            @(negedge clk_1khz);
            start = 1'b0;
        end while (!conv_done && n < 30);
        check($sformatf("conv_latency_%0d", value), n, 10);
        check($sformatf("conv_bcd_%0d", value), bcd, exp_bcd);
        bin = ~value;
        @(negedge clk_1khz);
        check($sformatf("conv_done_pulse_%0d", value), conv_done, 0);
        check($sformatf("conv_hold_%0d", value), bcd, exp_bcd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        reset_in = 1'b1;
        done_in  = 1'b0;
        digit    = D1;
        start    = 1'b0;
        bin      = '0;
        repeat (3) @(negedge clk_1khz);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_frame_upd", frame_upd, 0);
        check("rst_conv_done", conv_done, 0);
        reset_in = 1'b0;

        // display registers stay zero until the first commit
        scan_check("boot", 32'h0000_0000);

        conv_test(10'd999,  16'h0999);
        conv_test(10'd1023, 16'h1023);
        conv_test(10'd0,    16'h0000);
        conv_test(10'd789,  16'h0789);

        // reset in the middle of the hr/min conversion (cycle 20)
        wait_frame(cyc);
        repeat (21) @(posedge clk_1khz);
        #2 reset_in = 1'b1;
        #1;
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1);
        check("midrst_frame_upd", frame_upd, 0);
        @(negedge clk_1khz);
        reset_in = 1'b0;
        wait_frame(cyc);
        check("first_frame_latency", cyc, 45);
        scan_check("d1", 32'h1234_5678);

        // change at cycle 5 of a frame: old value next commit, new after
        wait_frame(cyc);
        repeat (6) @(posedge clk_1khz);
        @(negedge clk_1khz);
        digit = D2;
        wait_frame(cyc);
        check("late_change_wait", cyc, 40);
        scan_check("old", 32'h1234_5678);
        wait_frame(cyc);
        scan_check("oor", 32'h3163_6302);

        wait_frame(cyc);
        wait_frame(cyc);
        check("frame_period", cyc, 46);

        // blink with BLINK_HALF=4
        @(negedge clk_1khz);
        done_in = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk_1khz);
            @(negedge clk_1khz);
            check($sformatf("blink%0d", k), (an == 8'hFF), ((k - 1) / 4) % 2);
        end
        done_in = 1'b0;
        @(posedge clk_1khz);
        @(negedge clk_1khz);
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk_1khz);
            @(negedge clk_1khz);
            check($sformatf("unblink%0d", k), (an == 8'hFF), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
